// File: rtl/mem_access_unit.sv
// Load/store front-end between the core and a word-addressed RAM without byte enables.
// Sub-word stores are read-modify-write; loads are lane-selected and sign/zero-extended.
module mem_access_unit #(
    parameter bit BIG_ENDIAN  = 1'b0,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] ram_address,
    output logic        ram_wren,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [15:0] wdata_q;

    logic        misaligned;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            if (req_size == 2'b01)
                misaligned = req_addr[0];
            else if (req_size[1])
                misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    // Big-endian mirrors the lane index; the RAM word itself is never byte-swapped.
    always_comb begin
        byte_lane = addr_q[1:0] ^ {2{BIG_ENDIAN}};
        half_lane = addr_q[1] ^ BIG_ENDIAN;

        case (byte_lane)
            2'd0:    load_byte = ram_q[7:0];
            2'd1:    load_byte = ram_q[15:8];
            2'd2:    load_byte = ram_q[23:16];
            default: load_byte = ram_q[31:24];
        endcase
        load_half = half_lane ? ram_q[31:16] : ram_q[15:0];

        case (size_q)
            2'b00:   load_data = {{24{signed_q & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{signed_q & load_half[15]}}, load_half};
            default: load_data = ram_q;
        endcase

        merged = ram_q;
        if (size_q == 2'b00) begin
            case (byte_lane)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (half_lane) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata[15:0];
                        if (misaligned)
                            state <= S_ERR;
                        else if (!req_we)
                            state <= S_LOAD;
                        else if (req_size[1])
                            state <= S_DONE;
                        else
                            state <= S_RMW;
                    end
                end
                S_RMW:   state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Full-word stores write straight from the request in the accept cycle; everything
    // else addresses the RAM from the latched request so the read issued at accept lines up.
    always_comb begin
        req_ready   = (state == S_IDLE);
        ram_address = (state == S_IDLE) ? req_addr[31:2] : addr_q[31:2];
        ram_wren    = 1'b0;
        ram_data    = '0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_we && req_size[1] && !misaligned) begin
                    ram_wren = 1'b1;
                    ram_data = req_wdata;
                end
            end
            S_LOAD: begin
                resp_valid = 1'b1;
                resp_rdata = load_data;
            end
            S_RMW: begin
                ram_wren = 1'b1;
                ram_data = merged;
            end
            S_DONE: resp_valid = 1'b1;
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: little-endian aligned unit with a scoreboard,
// plus big-endian and no-alignment-check variants exercised with direct checks.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_valid_be, req_valid_na;
    logic        req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err, ram_wren;
    logic [31:0] resp_rdata, ram_data, ram_q;
    logic [29:0] ram_address;

    logic        be_ready, be_resp_valid, be_resp_err, be_ram_wren;
    logic [31:0] be_resp_rdata, be_ram_data, be_ram_q;
    logic [29:0] be_ram_address;

    logic        na_ready, na_resp_valid, na_resp_err, na_ram_wren;
    logic [31:0] na_resp_rdata, na_ram_data, na_ram_q;
    logic [29:0] na_ram_address;

    mem_access_unit #(.BIG_ENDIAN(1'b0), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_address(ram_address),
        .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q));

    mem_access_unit #(.BIG_ENDIAN(1'b1), .CHECK_ALIGN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_be), .req_ready(be_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(be_resp_valid),
        .resp_rdata(be_resp_rdata), .resp_err(be_resp_err), .ram_address(be_ram_address),
        .ram_wren(be_ram_wren), .ram_data(be_ram_data), .ram_q(be_ram_q));

    mem_access_unit #(.BIG_ENDIAN(1'b0), .CHECK_ALIGN(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_na), .req_ready(na_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(na_resp_valid),
        .resp_rdata(na_resp_rdata), .resp_err(na_resp_err), .ram_address(na_ram_address),
        .ram_wren(na_ram_wren), .ram_data(na_ram_data), .ram_q(na_ram_q));

    // Registered-read RAM models; the preload port lets the bench seed words.
    logic [31:0] mem    [0:15];
    logic [31:0] mem_be [0:15];
    logic [31:0] mem_na [0:15];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [31:0] pre_data;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) begin
            mem[pre_addr]    <= pre_data;
            mem_be[pre_addr] <= pre_data;
            mem_na[pre_addr] <= pre_data;
        end else begin
            if (ram_wren)    mem[ram_address[3:0]]       <= ram_data;
            if (be_ram_wren) mem_be[be_ram_address[3:0]] <= be_ram_data;
            if (na_ram_wren) mem_na[na_ram_address[3:0]] <= na_ram_data;
        end
        ram_q    <= mem[ram_address[3:0]];
        be_ram_q <= mem_be[be_ram_address[3:0]];
        na_ram_q <= mem_na[na_ram_address[3:0]];
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL sb_unexpected_resp: got err=%0b rdata=%h, expected no response",
                         resp_err, resp_rdata);
            end else begin
                cur = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== {cur.err, cur.rdata}) begin
                    n_fail++;
                    $display("[TB] FAIL sb_resp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                             resp_err, resp_rdata, cur.err, cur.rdata);
                end
            end
        end
    end

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request to the main unit, queues its expected response and reports
    // accept-cycle RAM signals, latency and how many post-accept cycles wrote RAM.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           output int lat, output logic wren_acc, output logic [29:0] addr_acc,
                           output logic [31:0] data_acc, output int wren_after, output int acc_cyc);
        logic rdy;
        exp_q.push_back(exp_t'{err: exp_err, rdata: exp_rdata});
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        rdy = 1'b0; lat = -1; wren_after = 0; acc_cyc = -1;
        wren_acc = 1'b0; addr_acc = '0; data_acc = '0;
        for (int i = 0; i < 10 && !rdy; i++) begin
            #1;
            rdy = req_ready; wren_acc = ram_wren; addr_acc = ram_address; data_acc = ram_data;
            @(posedge clk);
            if (!rdy) @(negedge clk);
        end
        #1;
        req_valid = 1'b0;
        acc_cyc = cyc;
        if (rdy) begin
            for (int k = 1; k <= 8 && lat < 0; k++) begin
                @(negedge clk);
                if (ram_wren) wren_after++;
                if (resp_valid) lat = k;
            end
        end
    endtask

    task automatic variant_load(input bit use_be, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, output logic v, output logic [31:0] d,
                                output logic e);
        req_we = 1'b0; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = '0;
        if (use_be) req_valid_be = 1'b1; else req_valid_na = 1'b1;
        @(posedge clk); #1;
        req_valid_be = 1'b0; req_valid_na = 1'b0;
        @(negedge clk);
        v = use_be ? be_resp_valid : na_resp_valid;
        d = use_be ? be_resp_rdata : na_resp_rdata;
        e = use_be ? be_resp_err : na_resp_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_valid_be = 0; req_valid_na = 0;
        req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        pre_we = 0; pre_addr = 0; pre_data = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, ram_wren} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got ready/valid/err/wren=%b, expected 1000",
                     {req_ready, resp_valid, resp_err, ram_wren});
        end
        n_cmp++;
        if ({resp_rdata, ram_data, ram_address} !== 94'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got rdata=%h ram_data=%h ram_address=%h, expected zeros",
                     resp_rdata, ram_data, ram_address);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        typedef struct packed { logic [1:0] size; logic sgn; logic [31:0] addr; logic [31:0] exp; } ld_t;
        ld_t tbl[11];
        int lat, wa, ac;
        logic wacc;
        logic [29:0] aacc;
        logic [31:0] dacc;
        tbl[0]  = '{2'b00, 1'b1, 32'd4, 32'h0000_0001};
        tbl[1]  = '{2'b00, 1'b1, 32'd6, 32'hFFFF_FFFF};
        tbl[2]  = '{2'b00, 1'b0, 32'd7, 32'h0000_0080};
        tbl[3]  = '{2'b00, 1'b1, 32'd7, 32'hFFFF_FF80};
        tbl[4]  = '{2'b00, 1'b0, 32'd6, 32'h0000_00FF};
        tbl[5]  = '{2'b01, 1'b1, 32'd6, 32'hFFFF_80FF};
        tbl[6]  = '{2'b01, 1'b0, 32'd4, 32'h0000_7F01};
        tbl[7]  = '{2'b01, 1'b1, 32'd4, 32'h0000_7F01};
        tbl[8]  = '{2'b01, 1'b0, 32'd6, 32'h0000_80FF};
        tbl[9]  = '{2'b10, 1'b0, 32'd4, 32'h80FF_7F01};
        tbl[10] = '{2'b11, 1'b1, 32'd4, 32'h80FF_7F01};
        preload(4'd1, 32'h80FF_7F01);
        for (int i = 0; i < 11; i++) begin
            run_req(1'b0, tbl[i].size, tbl[i].sgn, tbl[i].addr, 32'hA5A5_A5A5, 1'b0, tbl[i].exp,
                    lat, wacc, aacc, dacc, wa, ac);
            n_cmp++;
            if (lat !== 1) begin
                n_fail++;
                $display("[TB] FAIL load_latency[%0d]: got %0d, expected 1", i, lat);
            end
            n_cmp++;
            if ({wacc, dacc, aacc} !== {1'b0, 32'd0, 30'd1} || wa !== 0) begin
                n_fail++;
                $display("[TB] FAIL load_ram_port[%0d]: got wren=%0b data=%h addr=%h writes=%0d, expected 0/0/1/0",
                         i, wacc, dacc, aacc, wa);
            end
        end
    endtask

    task automatic test_rmw();
        int lat, wa, ac;
        logic wacc;
        logic [29:0] aacc;
        logic [31:0] dacc;
        logic [31:0] exp_word[3];
        logic [1:0]  sz[3];
        logic [31:0] ad[3];
        logic [31:0] wd[3];
        exp_word[0] = 32'h1122_AA44; sz[0] = 2'b00; ad[0] = 32'd5; wd[0] = 32'h0000_00AA;
        exp_word[1] = 32'hBEEF_AA44; sz[1] = 2'b01; ad[1] = 32'd6; wd[1] = 32'h0000_BEEF;
        exp_word[2] = 32'hBEEF_AA55; sz[2] = 2'b00; ad[2] = 32'd4; wd[2] = 32'hFFFF_FF55;
        preload(4'd1, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            run_req(1'b1, sz[i], 1'b0, ad[i], wd[i], 1'b0, 32'd0, lat, wacc, aacc, dacc, wa, ac);
            n_cmp++;
            if (lat !== 2) begin
                n_fail++;
                $display("[TB] FAIL rmw_latency[%0d]: got %0d, expected 2", i, lat);
            end
            n_cmp++;
            if (wacc !== 1'b0 || wa !== 1) begin
                n_fail++;
                $display("[TB] FAIL rmw_wren[%0d]: got accept=%0b later=%0d, expected 0 and 1", i, wacc, wa);
            end
            n_cmp++;
            if (mem[1] !== exp_word[i]) begin
                n_fail++;
                $display("[TB] FAIL rmw_word[%0d]: got %h, expected %h", i, mem[1], exp_word[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, wa, sw_cyc, lw_cyc;
        logic wacc;
        logic [29:0] aacc;
        logic [31:0] dacc;
        run_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF, 1'b0, 32'd0, lat, wacc, aacc, dacc, wa, sw_cyc);
        n_cmp++;
        if ({wacc, aacc, dacc} !== {1'b1, 30'd2, 32'hDEAD_BEEF} || wa !== 0) begin
            n_fail++;
            $display("[TB] FAIL sw_accept: got wren=%0b addr=%h data=%h later=%0d, expected 1/2/deadbeef/0",
                     wacc, aacc, dacc, wa);
        end
        n_cmp++;
        if (lat !== 1 || mem[2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("[TB] FAIL sw_result: got lat=%0d word=%h, expected 1 and deadbeef", lat, mem[2]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 1'b0, 32'hDEAD_BEEF, lat, wacc, aacc, dacc, wa, lw_cyc);
        n_cmp++;
        if (lw_cyc !== sw_cyc + 2 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_spacing: got accept gap=%0d lat=%0d, expected 2 and 1",
                     lw_cyc - sw_cyc, lat);
        end
    endtask

    task automatic test_misaligned();
        int lat, wa, ac;
        logic wacc;
        logic [29:0] aacc;
        logic [31:0] dacc;
        logic        we[3];
        logic [1:0]  sz[3];
        logic [31:0] ad[3];
        we[0] = 1'b0; sz[0] = 2'b10; ad[0] = 32'd6;
        we[1] = 1'b1; sz[1] = 2'b01; ad[1] = 32'd5;
        we[2] = 1'b1; sz[2] = 2'b11; ad[2] = 32'd9;
        preload(4'd1, 32'h80FF_7F01);
        preload(4'd2, 32'h0BAD_F00D);
        for (int i = 0; i < 3; i++) begin
            run_req(we[i], sz[i], 1'b0, ad[i], 32'h0000_BEEF, 1'b1, 32'd0, lat, wacc, aacc, dacc, wa, ac);
            n_cmp++;
            if (lat !== 1 || wacc !== 1'b0 || wa !== 0) begin
                n_fail++;
                $display("[TB] FAIL misaligned[%0d]: got lat=%0d wren=%0b later=%0d, expected 1/0/0",
                         i, lat, wacc, wa);
            end
        end
        n_cmp++;
        if (mem[1] !== 32'h80FF_7F01 || mem[2] !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("[TB] FAIL misaligned_ram: got %h %h, expected 80ff7f01 0badf00d", mem[1], mem[2]);
        end
    endtask

    task automatic test_variants();
        logic v, e;
        logic [31:0] d;
        preload(4'd1, 32'h80FF_7F01);
        variant_load(1'b1, 2'b01, 1'b1, 32'd4, v, d, e);
        n_cmp++;
        if ({v, e, d} !== {1'b1, 1'b0, 32'hFFFF_80FF}) begin
            n_fail++;
            $display("[TB] FAIL be_lh4: got valid=%0b err=%0b rdata=%h, expected 1/0/ffff80ff", v, e, d);
        end
        variant_load(1'b1, 2'b00, 1'b0, 32'd5, v, d, e);
        n_cmp++;
        if ({v, e, d} !== {1'b1, 1'b0, 32'h0000_00FF}) begin
            n_fail++;
            $display("[TB] FAIL be_lbu5: got valid=%0b err=%0b rdata=%h, expected 1/0/000000ff", v, e, d);
        end
        variant_load(1'b0, 2'b10, 1'b0, 32'd6, v, d, e);
        n_cmp++;
        if ({v, e, d} !== {1'b1, 1'b0, 32'h80FF_7F01}) begin
            n_fail++;
            $display("[TB] FAIL na_lw6: got valid=%0b err=%0b rdata=%h, expected 1/0/80ff7f01", v, e, d);
        end
        variant_load(1'b0, 2'b01, 1'b1, 32'd7, v, d, e);
        n_cmp++;
        if ({v, e, d} !== {1'b1, 1'b0, 32'hFFFF_80FF}) begin
            n_fail++;
            $display("[TB] FAIL na_lh7: got valid=%0b err=%0b rdata=%h, expected 1/0/ffff80ff", v, e, d);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int seen = 0;
        int lat, wa, ac;
        logic wacc;
        logic [29:0] aacc;
        logic [31:0] dacc;
        preload(4'd1, 32'h1122_3344);
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd4;
        req_wdata = 32'h0000_00AA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if (ram_wren !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_rmw_entered: got wren=%0b, expected 1", ram_wren);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ram_wren !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_async: got wren=%0b ready=%0b, expected 0 and 1", ram_wren, req_ready);
        end
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_cmp++;
        if (mem[1] !== 32'h1122_3344 || seen !== 0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_rmw_dropped: got word=%h resps=%0d ready=%0b, expected 11223344/0/1",
                     mem[1], seen, req_ready);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b0, 32'h1122_3344, lat, wacc, aacc, dacc, wa, ac);
        n_cmp++;
        if (lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL rst_recover: got lat=%0d, expected 1", lat);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_loads();
        test_rmw();
        test_back_to_back();
        test_misaligned();
        test_variants();
        test_reset_mid_rmw();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL sb_drain: got %0d outstanding responses, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
